// File: rtl/uart_core.sv
// uart_core: UART with a 16x oversampling tick, configurable frame format,
// first-word-fall-through TX/RX FIFOs and sticky receive error flags.
module uart_core #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        txen,
    input  logic                        rxen,
    input  logic [DIV_W-1:0]            div,
    input  logic [1:0]                  parity,
    input  logic                        stop2,
    output logic                        tx,
    input  logic                        rx,
    input  logic                        write,
    input  logic [DATA_W-1:0]           wrdata,
    output logic                        isfull,
    input  logic                        read,
    output logic [DATA_W-1:0]           rddata,
    output logic                        datardy,
    output logic [$clog2(FIFO_DEPTH):0] txcount,
    output logic [$clog2(FIFO_DEPTH):0] rxcount,
    output logic                        txidle,
    output logic                        perr,
    output logic                        ferr,
    output logic                        ovr,
    input  logic                        errclr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0] LAST = 3'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic par_en, par_odd;
    assign par_en  = parity == 2'b01 || parity == 2'b10;
    assign par_odd = parity == 2'b10;

    // A comparison rather than equality keeps the divider sane if DIV shrinks mid-count.
    logic [DIV_W-1:0] bcnt;
    logic             tick;
    assign tick = en && bcnt >= div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bcnt <= '0;
        else
            bcnt <= (!en || tick) ? '0 : bcnt + 1'b1;
    end

    logic [DATA_W-1:0] tmem [FIFO_DEPTH];
    logic [AW-1:0]     twp, trp;
    logic              t_push, t_pop, t_empty;
    logic [DATA_W-1:0] thead;

    assign t_push  = write && !isfull;
    assign t_empty = txcount == '0;
    assign isfull  = txcount == FULL;
    assign thead   = tmem[trp];

    always_ff @(posedge clk) begin
        if (t_push)
            tmem[twp] <= wrdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            twp     <= '0;
            trp     <= '0;
            txcount <= '0;
        end else begin
            if (t_push)
                twp <= twp + 1'b1;
            if (t_pop)
                trp <= trp + 1'b1;
            txcount <= txcount + (AW+1)'(t_push) - (AW+1)'(t_pop);
        end
    end

    state_t            tstate;
    logic [DATA_W-1:0] tsh;
    logic [2:0]        tbit;
    logic [3:0]        tcnt;
    logic              tpar, tsec, t_end, t_done;

    assign t_end  = tcnt == 4'hf;
    assign t_done = tstate == STOP && t_end && (!stop2 || tsec);
    // Loading straight from the end of a stop bit keeps queued frames back to back.
    assign t_pop  = tick && txen && !t_empty && (tstate == IDLE || t_done);
    assign txidle = tstate == IDLE && t_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstate <= IDLE;
            tx     <= 1'b1;
            tsh    <= '0;
            tbit   <= '0;
            tcnt   <= '0;
            tpar   <= 1'b0;
            tsec   <= 1'b0;
        end else if (!en) begin
            tstate <= IDLE;
            tx     <= 1'b1;
            tcnt   <= '0;
        end else if (tick) begin
            tcnt <= tcnt + 1'b1;
            if (t_pop) begin
                tstate <= START;
                tx     <= 1'b0;
                tcnt   <= '0;
                tsh    <= thead;
                tpar   <= ^thead ^ par_odd;
                tsec   <= 1'b0;
            end else if (tstate != IDLE && t_end) begin
                case (tstate)
                    START: begin
                        tstate <= DATA;
                        tx     <= tsh[0];
                        tsh    <= tsh >> 1;
                        tbit   <= '0;
                    end
                    DATA: begin
                        if (tbit == LAST) begin
                            tstate <= par_en ? PAR : STOP;
                            tx     <= par_en ? tpar : 1'b1;
                        end else begin
                            tx   <= tsh[0];
                            tsh  <= tsh >> 1;
                            tbit <= tbit + 1'b1;
                        end
                    end
                    PAR: begin
                        tstate <= STOP;
                        tx     <= 1'b1;
                    end
                    STOP: begin
                        if (stop2 && !tsec)
                            tsec <= 1'b1;
                        else
                            tstate <= IDLE;
                    end
                    default: tstate <= IDLE;
                endcase
            end
        end
    end

    logic [1:0] sync;
    logic       rs;
    assign rs = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync <= 2'b11;
        else
            sync <= {sync[0], rx};
    end

    state_t            rstate;
    logic [DATA_W-1:0] rsh;
    logic [2:0]        rbit;
    logic [3:0]        rcnt;
    logic              rpar, r_end, rx_wr;

    assign r_end = rcnt == 4'hf;
    assign rx_wr = tick && rstate == STOP && r_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate <= IDLE;
            rsh    <= '0;
            rbit   <= '0;
            rcnt   <= '0;
            rpar   <= 1'b0;
        end else if (!en) begin
            rstate <= IDLE;
            rcnt   <= '0;
        end else if (tick) begin
            rcnt <= rcnt + 1'b1;
            case (rstate)
                IDLE: begin
                    if (rxen && !rs) begin
                        rstate <= START;
                        rcnt   <= '0;
                    end
                end
                START: begin
                    if (rcnt == 4'd7) begin
                        rstate <= rs ? IDLE : DATA;
                        rcnt   <= '0;
                        rbit   <= '0;
                    end
                end
                DATA: begin
                    if (r_end) begin
                        rsh  <= {rs, rsh[DATA_W-1:1]};
                        rbit <= rbit + 1'b1;
                        if (rbit == LAST)
                            rstate <= par_en ? PAR : STOP;
                    end
                end
                PAR: begin
                    if (r_end) begin
                        rpar   <= rs;
                        rstate <= STOP;
                    end
                end
                STOP: begin
                    if (r_end)
                        rstate <= IDLE;
                end
                default: rstate <= IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] rmem [FIFO_DEPTH];
    logic [AW-1:0]     rwp, rrp;
    logic              r_push, r_pop, r_full;
    logic              perr_ev, ferr_ev, ovr_ev;

    assign r_full  = rxcount == FULL;
    assign r_push  = rx_wr && !r_full;
    assign r_pop   = read && datardy;
    assign datardy = rxcount != '0;
    assign rddata  = datardy ? rmem[rrp] : '0;
    assign ferr_ev = rx_wr && !rs;
    assign perr_ev = rx_wr && par_en && (rpar != (^rsh ^ par_odd));
    assign ovr_ev  = rx_wr && r_full;

    always_ff @(posedge clk) begin
        if (r_push)
            rmem[rwp] <= rsh;
    end

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rwp     <= '0;
            rrp     <= '0;
            rxcount <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            if (r_push)
                rwp <= rwp + 1'b1;
            if (r_pop)
                rrp <= rrp + 1'b1;
            rxcount <= rxcount + (AW+1)'(r_push) - (AW+1)'(r_pop);
            perr    <= (perr && !errclr) || perr_ev;
            ferr    <= (ferr && !errclr) || ferr_ev;
            ovr     <= (ovr && !errclr) || ovr_ev;
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: random and directed checks of uart_core against a frame-level
// model of the serial format and a queue model of the receive FIFO.
module tb_uart_core;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 0, rst_n = 0, en = 0, txen = 0, rxen = 0, stop2 = 0;
    logic [15:0]   div = 0;
    logic [1:0]    parity = 0;
    logic          tx, rx, rx_drv = 1, loop = 0;
    logic          write = 0, read = 0, errclr = 0;
    logic [7:0]    wrdata = 0, rddata;
    logic          isfull, datardy, txidle, perr, ferr, ovr;
    logic [CW-1:0] txcount, rxcount;

    logic          en7 = 0, write7 = 0;
    logic [6:0]    wrdata7 = 0, rddata7;
    logic          tx7, isfull7, datardy7, txidle7, perr7, ferr7, ovr7;
    logic [CW-1:0] txcount7, rxcount7;

    logic sel7 = 0, txs, idles;
    assign rx    = loop ? tx : rx_drv;
    assign txs   = sel7 ? tx7 : tx;
    assign idles = sel7 ? txidle7 : txidle;

    int n_chk = 0, n_fail = 0, cyc = 0, last_tf = 0;

    uart_core #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV_W(16)) u8 (
        .clk(clk), .rst_n(rst_n), .en(en), .txen(txen), .rxen(rxen), .div(div),
        .parity(parity), .stop2(stop2), .tx(tx), .rx(rx), .write(write),
        .wrdata(wrdata), .isfull(isfull), .read(read), .rddata(rddata),
        .datardy(datardy), .txcount(txcount), .rxcount(rxcount), .txidle(txidle),
        .perr(perr), .ferr(ferr), .ovr(ovr), .errclr(errclr));

    uart_core #(.DATA_W(7), .FIFO_DEPTH(DEPTH), .DIV_W(16)) u7 (
        .clk(clk), .rst_n(rst_n), .en(en7), .txen(1'b1), .rxen(1'b0), .div(div),
        .parity(2'b10), .stop2(1'b1), .tx(tx7), .rx(1'b1), .write(write7),
        .wrdata(wrdata7), .isfull(isfull7), .read(1'b0), .rddata(rddata7),
        .datardy(datardy7), .txcount(txcount7), .rxcount(rxcount7), .txidle(txidle7),
        .perr(perr7), .ferr(ferr7), .ovr(ovr7), .errclr(1'b0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bitc();
        return 16 * (int'(div) + 1);
    endfunction

    function automatic logic has_par(input logic [1:0] p);
        return p == 2'b01 || p == 2'b10;
    endfunction

    function automatic int nbits(input int dw, input logic [1:0] p, input logic s2);
        return 1 + dw + (has_par(p) ? 1 : 0) + (s2 ? 2 : 1);
    endfunction

    function automatic logic par_bit(input logic [7:0] d, input int dw, input logic [1:0] p);
        int ones = 0;
        for (int k = 0; k < dw; k++) ones += int'(d[k]);
        return ((ones % 2) == 1) ^ (p == 2'b10);
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int dw, input logic [1:0] p, input int i);
        if (i == 0) return 1'b0;
        if (i <= dw) return d[i-1];
        if (i == dw + 1 && has_par(p)) return par_bit(d, dw, p);
        return 1'b1;
    endfunction

    task automatic tx_frame(input logic [7:0] d, input int dw, input logic [1:0] p,
                            input logic s2, output int t_fall);
        int k = 0;
        int n = nbits(dw, p, s2);
        int lim = 40 * bitc();
        while (txs !== 1'b0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("tx_start_seen", 32'(k < lim), 1);
        t_fall = cyc;
        repeat (bitc() / 2) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            check($sformatf("tx_bit%0d", i), 32'(txs), 32'(frame_bit(d, dw, p, i)));
            if (i < n - 1) repeat (bitc()) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag, input int tf, input int n);
        int k = 0;
        while (idles !== 1'b1 && k < 100 * bitc()) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(cyc - tf), 32'(n * bitc()));
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (int'(rxcount) != n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("rx_count_reach", 32'(rxcount), 32'(n));
    endtask

    task automatic wr(input logic [7:0] d);
        write  = 1;
        wrdata = d;
        @(negedge clk);
        write = 0;
    endtask

    task automatic rd(input logic [7:0] exp);
        check("rd_data", 32'(rddata), 32'(exp));
        read = 1;
        @(negedge clk);
        read = 0;
    endtask

    task automatic rx_send(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        int b = bitc();
        rx_drv = 0;
        repeat (b) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx_drv = d[i];
            repeat (b) @(negedge clk);
        end
        if (has_par(parity)) begin
            rx_drv = par_bit(d, DW, parity) ^ bad_par;
            repeat (b) @(negedge clk);
        end
        if (bad_stop) begin
            rx_drv = 0;
            repeat (b * 12 / 16) @(negedge clk);
        end
        rx_drv = 1;
        repeat (2 * b) @(negedge clk);
    endtask

    logic [7:0] b3 [3];
    logic [7:0] fb [DEPTH];
    logic [7:0] q [$];
    logic [7:0] d1, d2;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_isfull", 32'(isfull), 0);
        check("rst_rddata", 32'(rddata), 0);
        check("rst_datardy", 32'(datardy), 0);
        check("rst_txcount", 32'(txcount), 0);
        check("rst_rxcount", 32'(rxcount), 0);
        check("rst_txidle", 32'(txidle), 1);
        check("rst_errs", 32'({perr, ferr, ovr}), 0);
        rst_n = 1;
        en    = 1;
        en7   = 1;
        @(negedge clk);

        // Start latency with a tick every cycle.
        txen = 1;
        wr(8'h3C);
        check("lat_n1_tx", 32'(tx), 1);
        check("lat_txcount", 32'(txcount), 1);
        @(negedge clk);
        check("lat_n2_tx", 32'(tx), 0);
        begin
            int k = 0;
            while (txidle !== 1'b1 && k < 1000) begin
                @(negedge clk);
                k++;
            end
            check("lat_idle", 32'(txidle), 1);
        end

        div  = 3;
        loop = 1;
        rxen = 1;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) begin
                b3[0] = 8'hA5; b3[1] = 8'h00; b3[2] = 8'hFF;
                parity = 2'b01;
                stop2  = 0;
            end else begin
                for (int k = 0; k < 3; k++) b3[k] = 8'($urandom);
                parity = 2'($urandom_range(0, 3));
                stop2  = 1'($urandom_range(0, 1));
            end
            fork
                begin
                    int prev, tf;
                    prev = 0;
                    for (int k = 0; k < 3; k++) begin
                        tx_frame(b3[k], DW, parity, stop2, tf);
                        if (k > 0) check("tx_frame_len", 32'(tf - prev), 32'(nbits(DW, parity, stop2) * bitc()));
                        prev = tf;
                    end
                end
                begin
                    for (int k = 0; k < 3; k++) wr(b3[k]);
                end
            join
            wait_rx(3);
            check("loop_errs", 32'({perr, ferr, ovr}), 0);
            for (int k = 0; k < 3; k++) rd(b3[k]);
            check("loop_drained", 32'(datardy), 0);
        end
        loop = 0;
        rxen = 0;

        // 7 data bits, odd parity, two stop bits.
        sel7 = 1;
        fork
            begin
                int tf;
                tx_frame({1'b0, 7'h55}, 7, 2'b10, 1'b1, tf);
                wait_idle("tx7_frame_len", tf, 11);
            end
            begin
                write7  = 1;
                wrdata7 = 7'h55;
                @(negedge clk);
                write7 = 0;
            end
        join
        sel7 = 0;

        txen   = 0;
        parity = 2'b00;
        stop2  = 0;
        for (int k = 0; k < DEPTH; k++) begin
            fb[k] = 8'($urandom);
            wr(fb[k]);
        end
        check("fill_isfull", 32'(isfull), 1);
        check("fill_txcount", 32'(txcount), DEPTH);
        wr(8'($urandom));
        check("fill_extra_count", 32'(txcount), DEPTH);
        check("fill_tx_quiet", 32'(tx), 1);
        fork
            begin
                int prev, tf;
                prev = 0;
                for (int k = 0; k < DEPTH; k++) begin
                    tx_frame(fb[k], DW, 2'b00, 1'b0, tf);
                    if (k > 0) check("fill_frame_len", 32'(tf - prev), 32'(nbits(DW, 2'b00, 1'b0) * bitc()));
                    prev = tf;
                end
                last_tf = tf;
            end
            txen = 1;
        join
        wait_idle("fill_idle_end", last_tf, nbits(DW, 2'b00, 1'b0));

        rxen   = 1;
        parity = 2'b01;
        d1 = 8'($urandom);
        rx_send(d1, 1'b0, 1'b1);
        check("ferr_set", 32'(ferr), 1);
        check("perr_clean", 32'(perr), 0);
        d2 = 8'($urandom);
        rx_send(d2, 1'b1, 1'b0);
        check("perr_set", 32'(perr), 1);
        check("ferr_sticky", 32'(ferr), 1);
        check("err_frames_kept", 32'(rxcount), 2);
        rx_drv = 0;
        repeat (8 * (int'(div) + 1)) @(negedge clk);
        rx_drv = 1;
        repeat (5 * bitc()) @(negedge clk);
        check("glitch_no_frame", 32'(rxcount), 2);
        rd(d1);
        rd(d2);
        errclr = 1;
        @(negedge clk);
        errclr = 0;
        check("errclr", 32'({perr, ferr, ovr}), 0);

        parity = 2'b00;
        for (int k = 0; k < DEPTH + 1; k++) begin
            logic [7:0] d;
            d = 8'($urandom);
            rx_send(d, 1'b0, 1'b0);
            if (q.size() < DEPTH) q.push_back(d);
        end
        check("ovr_set", 32'(ovr), 1);
        check("ovr_count", 32'(rxcount), DEPTH);
        rd(q.pop_front());
        check("ovr_count_pop", 32'(rxcount), DEPTH - 1);
        d1 = 8'($urandom);
        fork
            rx_send(d1, 1'b0, 1'b0);
            begin
                int k = 0;
                while (u8.rx_wr !== 1'b1 && k < 2000) begin
                    @(negedge clk);
                    k++;
                end
                check("sim_sync", 32'(k < 2000), 1);
                check("sim_rd", 32'(rddata), 32'(q[0]));
                read = 1;
                @(negedge clk);
                read = 0;
                check("sim_count", 32'(rxcount), DEPTH - 1);
            end
        join
        void'(q.pop_front());
        q.push_back(d1);
        while (q.size() > 0) rd(q.pop_front());
        check("ovr_drained", 32'(datardy), 0);
        errclr = 1;
        @(negedge clk);
        errclr = 0;
        check("ovr_clr", 32'(ovr), 0);

        // Reset in the middle of a transmitted frame with data in both FIFOs.
        rx_send(8'($urandom), 1'b0, 1'b0);
        check("pre_rst_rxcount", 32'(rxcount), 1);
        wr(8'($urandom));
        wr(8'($urandom));
        begin
            int k = 0;
            while (tx !== 1'b0 && k < 1000) begin
                @(negedge clk);
                k++;
            end
            check("pre_rst_start", 32'(tx), 0);
        end
        repeat (3 * bitc()) @(negedge clk);
        check("pre_rst_txcount", 32'(txcount), 1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_tx", 32'(tx), 1);
        check("mid_rst_txcount", 32'(txcount), 0);
        check("mid_rst_rxcount", 32'(rxcount), 0);
        check("mid_rst_txidle", 32'(txidle), 1);
        check("mid_rst_rx_out", 32'({datardy, rddata}), 0);
        check("mid_rst_isfull", 32'(isfull), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (200) @(negedge clk);
        check("post_rst_tx", 32'(tx), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised UART controller, next generation of the team's fixed 8N1 UART: one clock domain, runtime baud divisor with 16x oversampling, configurable data width, parity and stop bits, parametrised TX/RX FIFOs, and sticky receive error flags. It sits between a register/bus front end (byte-wide WRITE/READ handshake) and the TX/RX pins. It replaces the divided-clock scheme with a clock-enable tick, so all logic runs on CLK.

## Interface
- DATA_W, 8, data bits per frame, legal 5..8
- FIFO_DEPTH, 16, entries per FIFO, power of two, >= 2
- DIV_W, 16, width of DIV
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- EN  in  1  global enable; low aborts both FSMs immediately, FIFO contents kept
- TXEN, RXEN  in  1  per-direction enables, qualified by EN
- DIV  in  DIV_W  oversample tick period = DIV+1 CLK cycles; 16 ticks per bit
- PARITY  in  2  00 none, 01 even, 10 odd, 11 none
- STOP2  in  1  1 = two stop bits transmitted
- TX  out  1  serial out, idle high
- RX  in  1  serial in, asynchronous
- WRITE, WRDATA[DATA_W-1:0]  in  push to TX FIFO
- ISFULL  out  1  TX FIFO full
- READ  in  1  pop RX FIFO
- RDDATA  out  DATA_W  RX FIFO head (first-word fall-through)
- DATARDY  out  1  RX FIFO not empty
- TXCOUNT, RXCOUNT  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- TXIDLE  out  1  TX FSM idle and TX FIFO empty
- PERR, FERR, OVR  out  1  sticky parity, framing, overrun errors
- ERRCLR  in  1  clears all three sticky flags

## Operation
- Reset values: TX=1, ISFULL=0, RDDATA=0, DATARDY=0, counts=0, TXIDLE=1, PERR=FERR=OVR=0; FSMs IDLE, FIFOs empty, tick counter 0.
- Tick generator: counter increments each CLK, on reaching DIV emits one-cycle tick and returns to 0. Held at 0 while EN=0. DIV change takes effect at next wrap.
- FIFOs: WRITE when ISFULL ignored (no corruption); READ when DATARDY=0 ignored. Simultaneous push/pop on non-empty, non-full FIFO: both occur, count unchanged. Pointers wrap modulo FIFO_DEPTH.
- TX FSM: IDLE, START, DATA, PARITY, STOP. In IDLE with EN&TXEN and TX FIFO non-empty, on a tick: load shift register, pop FIFO (one-cycle internal read), enter START. Each bit lasts 16 ticks. DATA sends LSB first, DATA_W bits. PARITY state skipped when PARITY is 00/11; even = XOR of data, odd = its inverse. STOP lasts 16 or 32 ticks (STOP2). TXEN falling mid-frame: current frame completes, no further pops. TX registered.
- RX: RX passes a 2-flop synchroniser. FSM IDLE, START, DATA, PARITY, STOP. IDLE->START on tick with synced RX=0. START: after 8 ticks resample; 1 = false start, back to IDLE; 0 -> DATA. DATA/PARITY/STOP sample every 16 ticks (mid-bit). Only the first stop bit is checked. At stop sample: STOP=0 sets FERR; parity mismatch sets PERR; frame written to RX FIFO regardless of errors unless FIFO full, then frame dropped and OVR set. Return to IDLE at mid-stop.
- PARITY/STOP2/DIV changes mid-frame: undefined frame, FSMs must still return to IDLE.
- EN=0: both FSMs to IDLE next CLK, TX=1, no FIFO side effects. RXEN=0 in IDLE blocks start detection; mid-frame RXEN fall completes frame.
- ERRCLR same cycle as a new error event: error wins (flag stays 1).

## Timing
- WRITE at cycle n with DIV=0, TX idle: TX low at n+2.
- Frame length: (1+DATA_W+P+S)*16*(DIV+1) CLK cycles, P=0/1, S=1/2.
- RX write to FIFO: DATARDY high 1 cycle after mid-stop sample (plus 2-cycle synchroniser latency from pin).
- READ at cycle n: RDDATA shows next entry at n+1; DATARDY falls at n+1 if last entry.
- ISFULL/counts update the cycle after the push/pop.

## Test plan
- Reset mid-frame (RST low during DATA): all outputs at reset values immediately; TX=1; counts 0.
- Loopback TX->RX, DIV=3, 8E1, send 0xA5,0x00,0xFF: RX FIFO returns same bytes in order, PERR=FERR=OVR=0, TX frame 11*64 cycles each.
- DATA_W=7, PARITY=10, STOP2=1, send 0x55: TX waveform start,1010101,parity=1,two stop highs; frame 11*16*(DIV+1) cycles.
- Fill TX FIFO with TXEN=0: ISFULL after FIFO_DEPTH writes, extra WRITE ignored, TXCOUNT=FIFO_DEPTH; enable -> all FIFO_DEPTH bytes sent, TXIDLE=1 at end.
- Drive RX with stop bit 0 then wrong parity: FERR then PERR set, both bytes in FIFO; ERRCLR clears; 8-tick glitch of 0 in IDLE produces no frame.
- RX FIFO full plus one more frame: frame dropped, OVR=1, RXCOUNT stays FIFO_DEPTH; simultaneous READ/frame-write on full-minus-one keeps count constant.
